// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bundle for im_loader.
// master: loader side (takes bytes, drives writes); slave: source/memory side.
interface im_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, we, waddr, wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, we, waddr, wdata
   );
endinterface

// File: rtl/im_loader.sv
// Instruction memory loader: packs big-endian bytes into words and writes them.
// Ports: clk, reset, start/num_words control, bus (bytes in, writes out), status.
module im_loader #(
   parameter int DEPTH = 30,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   im_loader_if.master      bus,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] words_loaded,
   output logic [31:0]      checksum
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] loaded_q, loaded_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [31:0]      shreg_q, shreg_d;
   logic [31:0]      waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      csum_q, csum_d;
   logic             ready_q, ready_d;
   logic             we_q, we_d;
   logic             hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept;
   logic [CNT_W-1:0] idx_inc;
   logic [CNT_W-1:0] target_new;
   logic [31:0]      word_next;

   assign accept     = bus.byte_valid & ready_q;
   assign idx_inc    = idx_q + CNT_W'(1);
   assign target_new = (num_words > DEPTH_W) ? DEPTH_W : num_words;
   // Shifting left means the first byte of a word ends up in [31:24].
   assign word_next  = {shreg_q[23:0], bus.byte_data};

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      target_d = target_q;
      loaded_d = loaded_q;
      bcnt_d   = bcnt_q;
      shreg_d  = shreg_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      csum_d   = csum_q;
      ready_d  = ready_q;
      we_d     = 1'b0;
      hold_d   = hold_q;
      busy_d   = busy_q;
      done_d   = done_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               target_d = target_new;
               idx_d    = '0;
               bcnt_d   = '0;
               loaded_d = '0;
               csum_d   = '0;
               if (target_new == '0) begin
                  state_d = DONE;
                  ready_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = RECV;
                  ready_d = 1'b1;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  hold_d  = 1'b1;
               end
            end
         end
         RECV: begin
            if (accept) begin
               shreg_d = word_next;
               bcnt_d  = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_d = WRITE;
                  ready_d = 1'b0;
                  we_d    = 1'b1;
                  waddr_d = 32'(idx_q) << 2;
                  wdata_d = word_next;
               end
            end
         end
         WRITE: begin
            idx_d    = idx_inc;
            loaded_d = loaded_q + CNT_W'(1);
            csum_d   = csum_q ^ wdata_q;
            if (idx_inc == target_q) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hold_d  = 1'b0;
            end else begin
               state_d = RECV;
               ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         target_q <= '0;
         loaded_q <= '0;
         bcnt_q   <= '0;
         shreg_q  <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         csum_q   <= '0;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         hold_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         target_q <= target_d;
         loaded_q <= loaded_d;
         bcnt_q   <= bcnt_d;
         shreg_q  <= shreg_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         csum_q   <= csum_d;
         ready_q  <= ready_d;
         we_q     <= we_d;
         hold_q   <= hold_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.byte_ready = ready_q;
   assign bus.we         = we_q;
   assign bus.waddr      = waddr_q;
   assign bus.wdata      = wdata_q;
   assign cpu_hold       = hold_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign words_loaded   = loaded_q;
   assign checksum       = csum_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: random byte gaps, queue-based write model.
// Drives on falling edge + 1, samples outputs at the same point.
module tb_im_loader;
   localparam int DEPTH = 30;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] num_words;
   logic             cpu_hold;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] words_loaded;
   logic [31:0]      checksum;

   im_loader_if bus ();

   im_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_words    (num_words),
      .bus          (bus),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .words_loaded (words_loaded),
      .checksum     (checksum)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int we_cyc   = 0;

   logic [31:0] words[$];
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         got_addr.push_back(bus.waddr);
         got_data.push_back(bus.wdata);
         we_cyc = cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts a load of n words from the global queue and streams its bytes.
   task automatic run(input int n, input bit gaps, input bit poke,
                      input int budget);
      int          bi;
      int          nexp;
      int          start_cyc;
      int          done_cyc;
      logic [31:0] w;
      logic [31:0] x;
      got_addr.delete();
      got_data.delete();
      nexp      = (n > DEPTH) ? DEPTH : n;
      start     = 1'b1;
      num_words = CNT_W'(n);
      step();
      start     = 1'b0;
      start_cyc = cyc;
      chk("start_busy", busy, nexp != 0);
      chk("start_ready", bus.byte_ready, nexp != 0);
      chk("start_hold", cpu_hold, nexp != 0);
      chk("start_done", done, nexp == 0);
      bi       = 0;
      done_cyc = -1;
      for (int c = 0; c < budget; c++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         start = poke && (c == 3);
         if (poke && c == 3) num_words = CNT_W'(9);
         bus.byte_valid = 1'b0;
         if (bi < words.size() * 4 && !(gaps && $urandom_range(3) == 0)) begin
            w = words[bi / 4];
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'(w >> (24 - 8 * (bi % 4)));
            if (bus.byte_ready) bi++;
         end
         step();
      end
      start          = 1'b0;
      bus.byte_valid = 1'b0;
      chk("timeout", done_cyc >= 0, 1);
      chk("nwrites", got_addr.size(), nexp);
      x = '0;
      for (int i = 0; i < nexp; i++) x ^= words[i];
      for (int i = 0; i < nexp && i < got_addr.size(); i++) begin
         chk($sformatf("waddr%0d", i), got_addr[i], i * 4);
         chk($sformatf("wdata%0d", i), got_data[i], words[i]);
      end
      chk("accepted", bi, 4 * nexp);
      if (nexp > 0) chk("done_lat", done_cyc, we_cyc + 1);
      if (nexp == 0) chk("zero_done_lat", done_cyc, start_cyc);
      if (nexp == 1 && !gaps) chk("word_cost", done_cyc - start_cyc, 5);
      chk("loaded", words_loaded, nexp);
      chk("checksum", checksum, x);
      chk("end_hold", cpu_hold, 0);
      chk("end_busy", busy, 0);
      chk("end_done", done, 1);
      chk("end_ready", bus.byte_ready, 0);
   endtask

   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      num_words      = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      step();
      step();
      reset = 1'b0;
      step();
      chk("rst_ready", bus.byte_ready, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_waddr", bus.waddr, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_loaded", words_loaded, 0);
      chk("rst_checksum", checksum, 0);

      words = '{32'h20080020};
      run(1, 1'b0, 1'b0, 50);

      words = '{32'h20080020, 32'h20090027, 32'h01098024};
      run(3, 1'b1, 1'b0, 200);

      words.delete();
      for (int i = 0; i < 40; i++) words.push_back($urandom);
      run(40, 1'b1, 1'b0, 1000);
      chk("last_waddr", bus.waddr, 32'h74);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_done_ready", bus.byte_ready, 0);
      end
      bus.byte_valid = 1'b0;
      chk("post_done_writes", got_addr.size(), 30);

      got_addr.delete();
      got_data.delete();
      start     = 1'b1;
      num_words = CNT_W'(1);
      step();
      start          = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h11;
      step();
      bus.byte_data  = 8'h22;
      step();
      bus.byte_valid = 1'b0;
      reset          = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("mid_rst_writes", got_addr.size(), 0);
      chk("mid_rst_hold", cpu_hold, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", bus.byte_ready, 0);
      chk("mid_rst_waddr", bus.waddr, 0);
      chk("mid_rst_loaded", words_loaded, 0);
      chk("mid_rst_checksum", checksum, 0);

      words = '{32'hAC100004};
      run(1, 1'b0, 1'b0, 50);

      words.delete();
      run(0, 1'b0, 1'b0, 20);

      words.delete();
      for (int i = 0; i < 3; i++) words.push_back($urandom);
      run(3, 1'b1, 1'b1, 200);

      words = '{32'h08000011};
      run(1, 1'b1, 1'b0, 80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
